// File: rtl/char_event_counter_if.sv
// char_event_counter_if
//   Groups the byte-in strobe, the live counter/event outputs and the TX
//   valid/ready stream of char_event_counter.
//   master : the environment (drives din/en/tx_ready, observes the rest)
//   slave  : the counter block itself
//   din/en        received byte and its one-cycle strobe
//   cnt/ovf       live counts (channel k at [k]) and sticky wrap/clamp flags
//   cnt_ready     pulse after an inc/dec, cnt_ch = channel of that event
//   led_rst       pulse after a clear
//   tx_data/tx_valid/tx_ready  report byte stream
//   busy          report in progress
interface char_event_counter_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [7:0]                   din;
  logic                         en;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt;
  logic [NUM_CH-1:0]            ovf;
  logic                         cnt_ready;
  logic [CH_W-1:0]              cnt_ch;
  logic                         led_rst;
  logic [7:0]                   tx_data;
  logic                         tx_valid;
  logic                         tx_ready;
  logic                         busy;

  modport master (
    output din, en, tx_ready,
    input  cnt, ovf, cnt_ready, cnt_ch, led_rst, tx_data, tx_valid, busy
  );

  modport slave (
    input  din, en, tx_ready,
    output cnt, ovf, cnt_ready, cnt_ch, led_rst, tx_data, tx_valid, busy
  );
endinterface

// File: rtl/char_event_counter.sv
// char_event_counter
//   Decodes bytes from the UART RX path into per-channel inc/dec/clear events
//   on NUM_CH counters, and on RPT_CHAR streams a hex snapshot of all counts
//   ("HH,HH,...,HH\n") through a valid/ready TX handshake.
//   clk  : system clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : char_event_counter_if.slave (byte input, counts, events, TX stream)
//
// char_event_lane holds one channel counter; the top instantiates NUM_CH of
// them and owns the command decode and the report FSM.

module char_event_lane #(
  parameter int CNT_W    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);
  localparam logic [CNT_W-1:0] MAX = '1;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      if (cnt == MAX) begin
        ovf <= 1'b1;
        if (!SATURATE) cnt <= '0;       // saturate mode simply holds
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else if (dec) begin
      if (cnt == '0) begin
        ovf <= 1'b1;
        if (!SATURATE) cnt <= MAX;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end
endmodule

module char_event_counter #(
  parameter int         NUM_CH   = 4,
  parameter int         CNT_W    = 8,
  parameter bit         SATURATE = 1'b0,
  parameter logic [7:0] CLR_CHAR = "@",
  parameter logic [7:0] RPT_CHAR = "?"
) (
  input  logic                 clk,
  input  logic                 rst,
  char_event_counter_if.slave  bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int D    = (CNT_W + 3) / 4;   // hex digits per channel
  localparam int PW   = 4 * D;             // nibble-padded width
  localparam int DW   = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [1:0] {IDLE, DIGIT, SEP, EOL} state_t;

  // ---------------- command decode ----------------
  logic                         clr_hit, rpt_hit, ev_hit;
  logic [NUM_CH-1:0]            inc_hit, dec_hit;
  logic [CH_W-1:0]              ev_ch;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_live;
  logic [NUM_CH-1:0]            ovf_live;

  always_comb begin
    clr_hit = bus.en && (bus.din == CLR_CHAR);
    rpt_hit = bus.en && (bus.din == RPT_CHAR);
    inc_hit = '0;
    dec_hit = '0;
    ev_ch   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      inc_hit[k] = bus.en && (bus.din == 8'(8'h61 + k));
      dec_hit[k] = bus.en && (bus.din == 8'(8'h41 + k));
      if (inc_hit[k] || dec_hit[k]) ev_ch = CH_W'(k);
    end
    // clear takes priority should CLR_CHAR ever alias a channel letter
    ev_hit = (|(inc_hit | dec_hit)) && !clr_hit;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    char_event_lane #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_lane (
      .clk (clk),
      .rst (rst),
      .inc (inc_hit[k]),
      .dec (dec_hit[k]),
      .clr (clr_hit),
      .cnt (cnt_live[k]),
      .ovf (ovf_live[k])
    );
  end

  assign bus.cnt = cnt_live;
  assign bus.ovf = ovf_live;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.cnt_ready <= 1'b0;
      bus.cnt_ch    <= '0;
      bus.led_rst   <= 1'b0;
    end else begin
      bus.cnt_ready <= ev_hit;
      bus.led_rst   <= clr_hit;
      if (ev_hit) bus.cnt_ch <= ev_ch;
    end
  end

  // ---------------- report FSM ----------------
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // nibble i (0 = least significant) of a zero-padded count
  function automatic logic [3:0] nib(input logic [CNT_W-1:0] v, input logic [DW-1:0] i);
    logic [PW-1:0] p;
    p = PW'(v) >> {i, 2'b00};
    return p[3:0];
  endfunction

  state_t                       state;
  logic [NUM_CH-1:0][CNT_W-1:0] shadow;
  logic [CH_W-1:0]              ch_idx, ch_nxt;
  logic [DW-1:0]                dig_idx;

  assign ch_nxt = ch_idx + CH_W'(1);

  // tx_valid is high in every non-IDLE state, so tx_ready alone marks a
  // handshake there; the next byte is loaded on that same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      shadow       <= '0;
      ch_idx       <= '0;
      dig_idx      <= '0;
      bus.tx_data  <= 8'h00;
      bus.tx_valid <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (rpt_hit) begin
          shadow       <= cnt_live;
          ch_idx       <= '0;
          dig_idx      <= DW'(D - 1);
          bus.tx_data  <= hex_char(nib(cnt_live[0], DW'(D - 1)));
          bus.tx_valid <= 1'b1;
          bus.busy     <= 1'b1;
          state        <= DIGIT;
        end
        DIGIT: if (bus.tx_ready) begin
          if (dig_idx != '0) begin
            dig_idx     <= dig_idx - DW'(1);
            bus.tx_data <= hex_char(nib(shadow[ch_idx], dig_idx - DW'(1)));
          end else if (ch_idx != CH_W'(NUM_CH - 1)) begin
            bus.tx_data <= 8'h2C;   // ","
            state       <= SEP;
          end else begin
            bus.tx_data <= 8'h0A;   // "\n"
            state       <= EOL;
          end
        end
        SEP: if (bus.tx_ready) begin
          ch_idx      <= ch_nxt;
          dig_idx     <= DW'(D - 1);
          bus.tx_data <= hex_char(nib(shadow[ch_nxt], DW'(D - 1)));
          state       <= DIGIT;
        end
        EOL: if (bus.tx_ready) begin
          bus.tx_valid <= 1'b0;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
